// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen: parametrised Avalon-MM parallel I/O port, zero-wait-state slave.
//
// Ports:
//   clk        - system clock (single domain)
//   reset_n    - asynchronous active-low reset
//   address    - word register select (0..7)
//   chipselect - slave select
//   write_n    - active-low write strobe, qualified by chipselect
//   writedata  - write data, bits above WIDTH ignored
//   readdata   - combinational read data, bits above WIDTH read as 0
//   in_port    - asynchronous external inputs
//   out_port   - registered output data
//   oe_port    - direction register, 1 = pad driven from out_port
//   irq        - level interrupt, |(edgecap & irqmask)
//
// Register map (read / write):
//   0 : dir ? data_out : in_sync / data_out <= wd
//   1 : dir / dir <= wd
//   2 : irqmask / irqmask <= wd
//   3 : edgecap / write-1-to-clear
//   4 : 0 / data_out |= wd
//   5 : 0 / data_out &= ~wd
//   6,7 : 0 / ignored
module avalon_pio_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] DATA_RESET  = 32'h0000_00FF,
  parameter logic [31:0] DIR_RESET   = 32'h0000_00FF,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] AddrData = 3'd0;
  localparam logic [2:0] AddrDir  = 3'd1;
  localparam logic [2:0] AddrMask = 3'd2;
  localparam logic [2:0] AddrEdge = 3'd3;
  localparam logic [2:0] AddrSet  = 3'd4;
  localparam logic [2:0] AddrClr  = 3'd5;

  // Edge detection is held off until the synchroniser and in_prev have been
  // refilled from in_port, so a level held through reset is not seen as an edge.
  localparam logic [2:0] GuardMax = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic [2:0]       guard_q, guard_d;
  logic             guard_done;
  logic             wr_en;

  // Upper writedata bits are intentionally ignored for narrow ports.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign in_sync = sync_q[SYNC_STAGES-1];

  // Register write decode.
  always_comb begin
    data_d   = data_q;
    dir_d    = dir_q;
    mask_d   = mask_q;
    clr_bits = '0;
    if (wr_en) begin
      case (address)
        AddrData: data_d   = wd;
        AddrDir:  dir_d    = wd;
        AddrMask: mask_d   = wd;
        AddrEdge: clr_bits = wd;
        AddrSet:  data_d   = data_q | wd;
        AddrClr:  data_d   = data_q & ~wd;
        default:  ;
      endcase
    end
  end

  always_comb begin
    if (EDGE_TYPE == 1) begin
      edge_raw = ~in_sync & in_prev_q;
    end else if (EDGE_TYPE == 2) begin
      edge_raw = in_sync ^ in_prev_q;
    end else begin
      edge_raw = in_sync & ~in_prev_q;
    end
  end

  assign guard_done = (guard_q == GuardMax);
  assign guard_d    = guard_done ? guard_q : guard_q + 3'd1;
  assign edge_det   = guard_done ? edge_raw : '0;

  // A new edge wins over a same-cycle write-1-to-clear.
  assign edgecap_d = (edgecap_q & ~clr_bits) | edge_det;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      in_prev_q <= '0;
      data_q    <= DATA_RESET[WIDTH-1:0];
      dir_q     <= DIR_RESET[WIDTH-1:0];
      mask_q    <= '0;
      edgecap_q <= '0;
      guard_q   <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      end else begin
        sync_q <= in_port;
      end
      in_prev_q <= in_sync;
      data_q    <= data_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      edgecap_q <= edgecap_d;
      guard_q   <= guard_d;
    end
  end

  always_comb begin
    case (address)
      AddrData: rd = (dir_q & data_q) | (~dir_q & in_sync);
      AddrDir:  rd = dir_q;
      AddrMask: rd = mask_q;
      AddrEdge: rd = edgecap_q;
      default:  rd = '0;
    endcase
  end

  always_comb begin
    readdata            = '0;
    readdata[WIDTH-1:0] = rd;
  end

  assign out_port = data_q;
  assign oe_port  = dir_q;
  assign irq      = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_gen.sv
`timescale 1ns/1ps
module tb_avalon_pio_gen;

  localparam int S0 = 2;
  localparam int S1 = 3;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata, readdata2;
  logic [7:0]  out_port, out_port2, oe_port, oe_port2;
  logic        irq, irq2;

  int checks = 0;
  int errors = 0;

  // Reference model state. Bus-visible registers are shared by both instances;
  // edge capture differs by synchroniser depth and edge type.
  logic [7:0] hist[$];
  logic [7:0] m_dout, m_dir, m_mask;
  logic [7:0] m_cap[2];
  int         m_s[2];
  int         m_et[2];

  avalon_pio_gen #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(S0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .in_port(in_port),
    .out_port(out_port), .oe_port(oe_port), .irq(irq)
  );

  avalon_pio_gen #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(S1)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2), .in_port(in_port),
    .out_port(out_port2), .oe_port(oe_port2), .irq(irq2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] samp(int k);
    if (k >= 1 && k <= hist.size()) return hist[k-1];
    return 8'h00;
  endfunction

  function automatic logic [7:0] det(int et, logic [7:0] cur, logic [7:0] prev);
    if (et == 1) return ~cur & prev;
    if (et == 2) return cur ^ prev;
    return cur & ~prev;
  endfunction

  function automatic logic [31:0] mread(int d, logic [2:0] a);
    logic [7:0] insync;
    insync = samp(hist.size() - m_s[d] + 1);
    case (a)
      3'd0: return {24'h0, (m_dir & m_dout) | (~m_dir & insync)};
      3'd1: return {24'h0, m_dir};
      3'd2: return {24'h0, m_mask};
      3'd3: return {24'h0, m_cap[d]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    m_dout = 8'hFF;
    m_dir  = 8'hFF;
    m_mask = 8'h00;
    m_cap[0] = 8'h00;
    m_cap[1] = 8'h00;
  endtask

  // Advance the model over one clock edge using the inputs as driven now, then
  // let the DUT take the same edge and settle.
  task automatic tick();
    logic [7:0] wd8, clr, edges;
    int n;
    if (!reset_n) begin
      model_reset();
    end else begin
      wd8 = writedata[7:0];
      clr = 8'h00;
      hist.push_back(in_port);
      n = hist.size();
      if (chipselect && !write_n && address == 3'd3) clr = wd8;
      for (int d = 0; d < 2; d++) begin
        edges = (n >= m_s[d] + 2) ? det(m_et[d], samp(n - m_s[d]), samp(n - m_s[d] - 1))
                                   : 8'h00;
        m_cap[d] = (m_cap[d] & ~clr) | edges;
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_dout = wd8;
          3'd1: m_dir  = wd8;
          3'd2: m_mask = wd8;
          3'd4: m_dout = m_dout | wd8;
          3'd5: m_dout = m_dout & ~wd8;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk({tag, " out"},  {24'h0, out_port},  {24'h0, m_dout});
    chk({tag, " oe"},   {24'h0, oe_port},   {24'h0, m_dir});
    chk({tag, " irq"},  {31'h0, irq},       {31'h0, |(m_cap[0] & m_mask)});
    chk({tag, " out2"}, {24'h0, out_port2}, {24'h0, m_dout});
    chk({tag, " oe2"},  {24'h0, oe_port2},  {24'h0, m_dir});
    chk({tag, " irq2"}, {31'h0, irq2},      {31'h0, |(m_cap[1] & m_mask)});
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #0.2;
      chk($sformatf("%s rd%0d", tag, a), readdata, mread(0, 3'(a)));
      chk($sformatf("%s rd2_%0d", tag, a), readdata2, mread(1, 3'(a)));
    end
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_lit(string tag, int which, logic [2:0] a, logic [31:0] exp);
    address = a;
    #0.2;
    chk(tag, (which == 0) ? readdata : readdata2, exp);
  endtask

  initial begin
    m_s[0] = S0;  m_et[0] = 0;
    m_s[1] = S1;  m_et[1] = 2;
    clk        = 1'b0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'hFF;
    model_reset();

    // Reset values, with in_port held high through release.
    tick();
    tick();
    check_all("reset");
    chk("reset out_lit", {24'h0, out_port}, 32'hFF);
    rd_lit("reset mask_lit", 0, 3'd2, 32'h0);
    rd_lit("reset cap_lit", 0, 3'd3, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_all("guard");
      rd_lit("guard cap_lit", 0, 3'd3, 32'h0);
      rd_lit("guard cap2_lit", 1, 3'd3, 32'h0);
    end
    in_port = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    check_all("fall");
    wr(3'd3, 32'hFF);
    check_all("clr0");

    // Data, set and clear writes; upper writedata bits ignored.
    wr(3'd0, 32'h5A);
    check_all("wdata");
    rd_lit("wdata lit", 0, 3'd0, 32'h5A);
    wr(3'd4, 32'h181);
    check_all("set");
    chk("set lit", {24'h0, out_port}, 32'hDB);
    wr(3'd5, 32'hF0F);
    check_all("clr");
    chk("clr lit", {24'h0, out_port}, 32'hD0);

    // Direction mux.
    wr(3'd1, 32'hF0);
    in_port = 8'h03;
    for (int i = 0; i < 3; i++) tick();
    check_all("dirmux");
    rd_lit("dirmux lit", 0, 3'd0, 32'hD3);

    // Rising capture and irq latency.
    in_port = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h01);
    check_all("arm");
    in_port = 8'h01;
    tick();
    check_all("e0");
    chk("e0 irq_lit", {31'h0, irq}, 32'h0);
    tick();
    check_all("e1");
    chk("e1 irq_lit", {31'h0, irq}, 32'h0);
    tick();
    check_all("e2");
    chk("e2 irq_lit", {31'h0, irq}, 32'h1);
    in_port = 8'h03;
    for (int i = 0; i < 3; i++) tick();
    check_all("bit1");
    rd_lit("bit1 cap_lit", 0, 3'd3, 32'h03);

    // Clear collision, then plain clear.
    wr(3'd3, 32'hFF);
    in_port = 8'h02;
    for (int i = 0; i < 5; i++) tick();
    wr(3'd3, 32'hFF);
    in_port = 8'h03;
    tick();
    tick();
    wr(3'd3, 32'h01);
    check_all("collide");
    rd_lit("collide lit", 0, 3'd3, 32'h01);
    wr(3'd3, 32'h01);
    check_all("w1c");
    chk("w1c irq_lit", {31'h0, irq}, 32'h0);

    // Any-edge instance: bit 3 up then down, captured each time.
    for (int i = 0; i < 4; i++) tick();
    wr(3'd3, 32'hFF);
    in_port = 8'h0B;
    for (int i = 0; i < 4; i++) tick();
    check_all("any_up");
    rd_lit("any_up lit", 1, 3'd3, 32'h08);
    wr(3'd3, 32'hFF);
    in_port = 8'h03;
    for (int i = 0; i < 4; i++) tick();
    check_all("any_dn");
    rd_lit("any_dn lit", 1, 3'd3, 32'h08);

    // Randomised bus traffic and input activity.
    for (int i = 0; i < 400; i++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    // Reset mid-capture discards pending edges and restores reset values.
    wr(3'd2, 32'hFF);
    wr(3'd3, 32'hFF);
    in_port = ~in_port;
    tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst irq_lit", {31'h0, irq}, 32'h0);
    tick();
    check_all("inrst");
    in_port = 8'($urandom);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all("postrst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
